rs_latch_driver: RTL and testbench
==================================

# rs_latch_driver

Synchronous front-end that converts set/reset requests into safe R/S/Enable waveforms for a downstream gated RS latch. Enforces the latch's forbidden-input and setup/hold rules. Optionally checks the latch's Q/Q_pr feedback after each write. Sits directly upstream of the gated latch: its R, S and Enable outputs wire straight to the latch inputs, and the latch outputs return as feedback.

## Interface
- SETUP_CYCLES, 1: cycles R/S are driven with Enable low before the enable pulse (≥1)
- PULSE_CYCLES, 2: Enable high width in cycles (≥1; 0 illegal)
- HOLD_CYCLES, 1: cycles R/S stay driven after Enable falls (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_op  in  1  1 = set (S), 0 = reset (R)
- req_ready  out  1  high only in IDLE
- R  out  1  latch reset input
- S  out  1  latch set input
- Enable  out  1  latch gate
- Q_fb  in  1  latch Q feedback
- Q_pr_fb  in  1  latch Q_pr feedback
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of each write
- error  out  1  sticky feedback mismatch flag
- err_clr  in  1  clears error

## Operation
- FSM states:
  - IDLE: req_ready=1; on req_valid, latch req_op and go to SETUP.
  - SETUP: drive the selected line, Enable=0; stays SETUP_CYCLES cycles.
  - PULSE: Enable=1, line still driven; stays PULSE_CYCLES cycles.
  - HOLD: Enable=0, line still driven; stays HOLD_CYCLES cycles.
  - CHECK: R=S=0, Enable=0; compare feedback; done=1; returns to IDLE. With the macro off, this state still exists but performs no compare.
- Set drives S=1, R=0; reset drives R=1, S=0. R and S are both 0 in IDLE and CHECK.
- Invariants:
  - R&S never 1.
  - Enable=1 only in PULSE.
  - R and S change only while Enable=0.
- All outputs are registered (driven from flops, no combinational path from inputs).
- A request is accepted only in IDLE. req_valid in other states is ignored, not queued.
- A single down-counter, reloaded at each state entry, times SETUP, PULSE and HOLD. Width is $clog2(max(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES)+1).
- error priority: a new mismatch in the same cycle as err_clr sets error (set wins).
- Reset at any time, including mid-pulse: at the next edge the FSM enters IDLE and R, S, Enable, busy, done and error all go to 0. req_ready is 1 after reset.

## Timing
- Reset values: req_ready=1, all other outputs 0.
- Defaults (SETUP=1, PULSE=2, HOLD=1), with the request accepted at edge 0:
  - SETUP during cycle 1
  - Enable high during cycles 2–3
  - HOLD during cycle 4
  - CHECK and done during cycle 5
  - req_ready high again in cycle 6
- General: the write occupies SETUP+PULSE+HOLD+1 cycles after acceptance. Maximum throughput is one request per SETUP+PULSE+HOLD+2 cycles.
- Feedback is sampled on the edge ending the CHECK cycle. The latch must settle within HOLD_CYCLES.

## Configuration
- RS_DRV_VERIFY_EN defined:
  - CHECK compares feedback; error sets if Q_fb≠req_op or Q_pr_fb==Q_fb.
  - err_clr is functional.
- RS_DRV_VERIFY_EN undefined:
  - No compare logic is built; error is tied to 0 and err_clr is unused.
  - The CHECK cycle still occurs, so timing is identical in both builds.

## Structure
- Package rs_drv_pkg holds:
  - state encoding: IDLE, SETUP, PULSE, HOLD, CHECK
  - OP_SET=1'b1, OP_RESET=1'b0
- Sub-module rs_drv_timer: loadable down-counter with load, value and zero outputs. It is the only sub-module.

## Test plan
- Reset then set: req_valid=1, req_op=1 at edge 0, feedback Q_fb=1, Q_pr_fb=0 → S=1 in cycles 1–4, Enable=1 in cycles 2–3, done in cycle 5, error=0, req_ready=1 in cycle 6.
- Reset op: req_op=0 with feedback Q_fb=0, Q_pr_fb=1 → R=1 in cycles 1–4, S=0 throughout, done in cycle 5.
- Busy ignore: second req_valid pulse in cycle 3 → ignored, only one done pulse, no change to R/S.
- Mismatch (macro on): set request with Q_fb held 0 → error=1 from cycle 6 until err_clr. Asserting err_clr in the same cycle as a new mismatch leaves error=1.
- Reset mid-pulse: reset asserted in cycle 2 → cycle 3 shows Enable=R=S=busy=0 and req_ready=1. A new request is accepted normally afterwards.
- Parameters SETUP=2, PULSE=3, HOLD=2: Enable high exactly 3 cycles, done at cycle 8. A checker confirms R&S never 1 and that R/S never toggle while Enable=1.

Source files
------------

// File: rtl/rs_drv_pkg.sv
// rs_drv_pkg: state encoding, op codes and sizing helper shared by rs_latch_driver
package rs_drv_pkg;
   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
   localparam logic OP_SET   = 1'b1;
   localparam logic OP_RESET = 1'b0;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/rs_drv_timer.sv
// rs_drv_timer: loadable down-counter that times each write phase
module rs_drv_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);
   always_ff @(posedge clk)
      if (reset) value <= '0;
      else if (load) value <= load_val;
      else if (value != '0) value <= value - 1'b1;
   assign zero = (value == '0);
endmodule

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: safe R/S/Enable sequencer for a gated RS latch
// Feedback verification is built only when RS_DRV_VERIFY_EN is defined.
module rs_latch_driver
   import rs_drv_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic req_valid,
   input  logic req_op,
   output logic req_ready,
   output logic R,
   output logic S,
   output logic Enable,
   input  logic Q_fb,
   input  logic Q_pr_fb,
   output logic busy,
   output logic done,
   output logic error,
   input  logic err_clr
);
   localparam int CW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);
   state_t state, nxt;
   logic op, op_nxt, load, zero, drive;
   logic [CW-1:0] load_val, cnt_unused;
   rs_drv_timer #(.W(CW)) u_timer (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_val(load_val),
      .value(cnt_unused),
      .zero(zero)
   );
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = req_valid ? SETUP : IDLE;
         SETUP:   nxt = zero ? PULSE : SETUP;
         PULSE:   nxt = zero ? HOLD : PULSE;
         HOLD:    nxt = zero ? CHECK : HOLD;
         CHECK:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
      op_nxt   = (state == IDLE && req_valid) ? req_op : op;
      load     = nxt != state;
      load_val = nxt == SETUP ? CW'(SETUP_CYCLES - 1) :
                 nxt == PULSE ? CW'(PULSE_CYCLES - 1) :
                 nxt == HOLD  ? CW'(HOLD_CYCLES - 1)  : '0;
      drive    = nxt inside {SETUP, PULSE, HOLD};
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk)
      if (reset) begin
         state     <= IDLE;
         op        <= OP_RESET;
         req_ready <= 1'b1;
         R         <= 1'b0;
         S         <= 1'b0;
         Enable    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= nxt;
         op        <= op_nxt;
         req_ready <= nxt == IDLE;
         R         <= drive && op_nxt == OP_RESET;
         S         <= drive && op_nxt == OP_SET;
         Enable    <= nxt == PULSE;
         busy      <= nxt != IDLE;
         done      <= nxt == CHECK;
      end
`ifdef RS_DRV_VERIFY_EN
   logic mismatch;
   assign mismatch = (Q_fb != op) || (Q_pr_fb == Q_fb);
   // a fresh mismatch beats a simultaneous clear
   always_ff @(posedge clk)
      if (reset) error <= 1'b0;
      else if (state == CHECK && mismatch) error <= 1'b1;
      else if (err_clr) error <= 1'b0;
`else
   logic fb_unused;
   assign fb_unused = ^{Q_fb, Q_pr_fb, err_clr};
   assign error = 1'b0;
`endif
endmodule

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver: scoreboard bench for rs_latch_driver at default and stretched timing
// Error expectations follow RS_DRV_VERIFY_EN.
module tb_rs_latch_driver;
   typedef struct packed {logic ready, r, s, en, busy, done, error;} exp_t;
`ifdef RS_DRV_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_valid1 = 1'b0, req_op = 1'b0;
   logic q_fb = 1'b0, q_pr_fb = 1'b1, err_clr = 1'b0;
   logic ready0, r0, s0, en0, busy0, done0, error0;
   logic ready1, r1, s1, en1, busy1, done1, error1;
   logic pr0 = 0, ps0 = 0, pe0 = 0, pr1 = 0, ps1 = 0, pe1 = 0, inv_bad;
   logic model_err [2] = '{1'b0, 1'b0};
   int total = 0, bad = 0;
   exp_t sb[$];
   always #5 clk = ~clk;
   rs_latch_driver dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_ready(ready0),
      .R(r0), .S(s0), .Enable(en0), .Q_fb(q_fb), .Q_pr_fb(q_pr_fb),
      .busy(busy0), .done(done0), .error(error0), .err_clr(err_clr)
   );
   rs_latch_driver #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_op(req_op), .req_ready(ready1),
      .R(r1), .S(s1), .Enable(en1), .Q_fb(q_fb), .Q_pr_fb(q_pr_fb),
      .busy(busy1), .done(done1), .error(error1), .err_clr(err_clr)
   );
   // R&S exclusion and R/S stability while Enable stays high, on both instances
   always @(negedge clk) begin
      inv_bad = (r0 && s0) || (r1 && s1) ||
                (en0 && pe0 && {r0, s0} != {pr0, ps0}) || (en1 && pe1 && {r1, s1} != {pr1, ps1});
      total++;
      assert (inv_bad === 1'b0) else begin
         bad++;
         $error("FAIL invariant got r0=%b s0=%b en0=%b r1=%b s1=%b en1=%b exp no overlap/toggle", r0, s0, en0, r1, s1, en1);
      end
      {pr0, ps0, pe0, pr1, ps1, pe1} = {r0, s0, en0, r1, s1, en1};
   end
   function automatic exp_t obs(input bit sel);
      return sel ? {ready1, r1, s1, en1, busy1, done1, error1} : {ready0, r0, s0, en0, busy0, done0, error0};
   endfunction
   task automatic check(input string tag, input exp_t got);
      exp_t e;
      e = sb.pop_front();
      total++;
      assert (got === e) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b (ready r s en busy done error)", tag, got, e);
      end
   endtask
   task automatic run_write(input string name, input bit sel, input logic op, input logic qf, input logic qp,
                            input int su, input int pu, input int ho,
                            input int poke_at, input int clr_at, input int rst_at);
      int n, last;
      logic err_after;
      exp_t e;
      n = su + pu + ho;
      last = (rst_at > 0) ? rst_at + 1 : n + 3;
      err_after = (VER && (qf != op || qp == qf)) || (model_err[sel] && clr_at != n + 1);
      for (int k = 1; k <= last; k++) begin
         if (rst_at > 0 && k > rst_at) e = 7'b1000000;
         else if (k <= n) e = {1'b0, ~op, op, k > su && k <= su + pu, 1'b1, 1'b0, model_err[sel]};
         else if (k == n + 1) e = {5'b00001, 1'b1, model_err[sel]};
         else e = {1'b1, 5'b00000, err_after};
         sb.push_back(e);
      end
      q_fb = qf;
      q_pr_fb = qp;
      req_op = op;
      if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_valid1 = 1'b0;
      req_op = ~op;
      for (int k = 1; k <= last; k++) begin
         check($sformatf("%s c%0d", name, k), obs(sel));
         if (k == poke_at) begin
            if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
            req_valid1 = 1'b0;
         end
         err_clr = (k == clr_at);
         reset = (k == rst_at);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      err_clr = 1'b0;
      req_valid = 1'b0;
      req_valid1 = 1'b0;
      if (rst_at > 0) model_err = '{1'b0, 1'b0};
      else model_err[sel] = err_after;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(7'b1000000);
      check("reset0", obs(1'b0));
      sb.push_back(7'b1000000);
      check("reset1", obs(1'b1));
      reset = 1'b0;
      @(posedge clk); #1;
      run_write("set", 1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 1, 0, 0, 0);
      run_write("rst_op", 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1, 0, 0, 0);
      run_write("busy_ign", 1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 1, 3, 0, 0);
      run_write("mism", 1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1, 0, 0, 0);
      run_write("mism_clr", 1'b0, 1'b0, 1'b1, 1'b1, 1, 2, 1, 0, 5, 0);
      sb.push_back(7'b1000000);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      model_err[0] = 1'b0;
      check("err_clr", obs(1'b0));
      run_write("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 1, 0, 0, 2);
      run_write("after_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1, 0, 0, 0);
      run_write("long_set", 1'b1, 1'b1, 1'b1, 1'b0, 2, 3, 2, 0, 0, 0);
      run_write("long_rst", 1'b1, 1'b0, 1'b0, 1'b1, 2, 3, 2, 4, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
